// File: rtl/mult_operand_dispatcher.sv
// Operand FIFO and control sequencer in front of a sequential multiplier: issues one start per
// operand pair, collects the product onto a valid/ready port and aborts a stalled operation.
module mult_operand_dispatcher #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_x,
  input  logic [WIDTH-1:0]           in_y,
  output logic [WIDTH-1:0]           mul_x,
  output logic [WIDTH-1:0]           mul_y,
  output logic                       mul_start,
  input  logic                       mul_done,
  input  logic [2*WIDTH-1:0]         mul_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WIDTH-1:0]         out_result,
  output logic                       out_err,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
  localparam logic [PtrW:0]  CntFull = (PtrW + 1)'(DEPTH);
  localparam logic [WdW-1:0] WdLast  = WdW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StDrop, StWait, StHold} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   mem_x [DEPTH];
  logic [WIDTH-1:0]   mem_y [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]      count_q, count_d;
  logic [WdW-1:0]     wd_q, wd_d;
  logic [WIDTH-1:0]   mul_x_q, mul_y_q;
  logic [2*WIDTH-1:0] out_result_q;
  logic               out_valid_q, out_err_q;
  logic               push, pop, capture, abort, clr_valid, wd_hit;

  // Full blocks pushes even when a pop happens in the same cycle.
  assign in_ready = (count_q != CntFull);
  assign push     = in_valid & in_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    pop       = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    clr_valid = 1'b0;
    wd_hit    = (wd_q == WdLast);
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wd_d    = '0;
        state_d = StDrop;
      end
      StDrop: begin
        // A Done left high by the previous operation must fall before a new one counts.
        wd_d = wd_q + 1'b1;
        if (wd_hit) begin
          abort   = 1'b1;
          state_d = StHold;
        end else if (!mul_done) begin
          state_d = StWait;
        end
      end
      StWait: begin
        wd_d = wd_q + 1'b1;
        if (mul_done) begin
          capture = 1'b1;
          state_d = StHold;
        end else if (wd_hit) begin
          abort   = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          clr_valid = 1'b1;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    mul_start = (state_q == StIssue);
    busy      = (state_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr_q] <= in_x;
      mem_y[wr_ptr_q] <= in_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wd_q         <= '0;
      mul_x_q      <= '0;
      mul_y_q      <= '0;
      out_result_q <= '0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      wd_q    <= wd_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        mul_x_q  <= mem_x[rd_ptr_q];
        mul_y_q  <= mem_y[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (capture) begin
        out_result_q <= mul_result;
        out_err_q    <= 1'b0;
        out_valid_q  <= 1'b1;
      end else if (abort) begin
        out_result_q <= '0;
        out_err_q    <= 1'b1;
        out_valid_q  <= 1'b1;
      end else if (clr_valid) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign mul_x      = mul_x_q;
  assign mul_y      = mul_y_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;
  assign count      = count_q;

endmodule
